// File: rtl/fmc_stream_fifo_pkg.sv
// Shared definitions for the FMC sample FIFO: FMC address map, status word
// layout and a helper that packs the status word.
package fmc_stream_fifo_pkg;

  localparam int unsigned DATA_W = 32;

  // FMC address map (fmc_addr[3:0])
  localparam logic [3:0] FMC_ADDR_FIFO   = 4'h4;
  localparam logic [3:0] FMC_ADDR_STATUS = 4'h8;

  // Status word bit positions; [15:0] holds the level
  localparam int unsigned STAT_EMPTY = 16;
  localparam int unsigned STAT_FULL  = 17;
  localparam int unsigned STAT_OVF   = 18;
  localparam int unsigned STAT_UNF   = 19;

  localparam logic [31:0] STATUS_RESET = 32'h0001_0000;

  function automatic logic [31:0] pack_status(input logic [15:0] level,
                                              input logic        empty,
                                              input logic        full,
                                              input logic        ovf,
                                              input logic        unf);
    logic [31:0] w;
    w             = '0;
    w[15:0]       = level;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_OVF]   = ovf;
    w[STAT_UNF]   = unf;
    return w;
  endfunction

endpackage

// File: rtl/fmc_stream_fifo_if.sv
// Sample stream, FMC strobes and read-mux outputs of the FMC sample FIFO.
interface fmc_stream_fifo_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        clr;
  logic [15:0] fmc_addr;
  logic        fmc_ne;
  logic        fmc_noe;
  logic [31:0] rd_data;
  logic [31:0] status;

  modport master (
    output s_data, s_valid, clr, fmc_addr, fmc_ne, fmc_noe,
    input  s_ready, rd_data, status
  );

  modport slave (
    input  s_data, s_valid, clr, fmc_addr, fmc_ne, fmc_noe,
    output s_ready, rd_data, status
  );
endinterface

// File: rtl/fmc_stream_fifo_strobe_sync.sv
// Synchronises the asynchronous FMC NE/NOE strobes into clk_i and reports
// NOE edges. Edges are suppressed until the chain holds real pin samples, so
// a strobe held low across reset is not mistaken for a fresh read.
module fmc_stream_fifo_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic fmc_ne_i,
  input  logic fmc_noe_i,
  output logic ne_s_o,
  output logic noe_s_o,
  output logic noe_fall_o,
  output logic noe_rise_o
);

  logic [SYNC_STAGES-1:0] ne_q;
  logic [SYNC_STAGES-1:0] noe_q;
  logic                   noe_prev_q;
  logic [SYNC_STAGES:0]   warm_q;

  // Shift pins through the synchroniser chain and track the previous NOE level
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ne_q       <= '1;
      noe_q      <= '1;
      noe_prev_q <= 1'b1;
      warm_q     <= '0;
    end else begin
      ne_q       <= {ne_q[SYNC_STAGES-2:0], fmc_ne_i};
      noe_q      <= {noe_q[SYNC_STAGES-2:0], fmc_noe_i};
      noe_prev_q <= noe_q[SYNC_STAGES-1];
      warm_q     <= {warm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign ne_s_o     = ne_q[SYNC_STAGES-1];
  assign noe_s_o    = noe_q[SYNC_STAGES-1];
  assign noe_fall_o = warm_q[SYNC_STAGES] &  noe_prev_q & ~noe_s_o;
  assign noe_rise_o = warm_q[SYNC_STAGES] & ~noe_prev_q &  noe_s_o;

endmodule

// File: rtl/fmc_stream_fifo.sv
// FMC sample FIFO: buffers a non-stallable DSP stream and presents the head
// word to the bridge read mux. A completed FMC read of the FIFO address pops.
// The word being moved from memory to the head (fetch_q) is still counted in
// the level, so the level is exact while a refill is in flight.
module fmc_stream_fifo
  import fmc_stream_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  FIFO_ADDR   = FMC_ADDR_FIFO
) (
  input logic              clk_i,
  input logic              reset_ni,
  fmc_stream_fifo_if.slave bus
);

  localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned          CW       = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0]  CNT_FULL = CW'(DEPTH);

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           rdata_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           head_q, head_d;
  logic                  head_valid_q, head_valid_d;
  logic                  fetch_q, fetch_d;
  logic                  sel_q, sel_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0]           status_q, status_d;
  logic [15:0]           level_d;

  logic ne_s, noe_s, noe_fall, noe_rise;
  logic pop_evt, pop_ok, full, issue, bypass, push_mem, load_head;
  logic unused_addr_hi;

  assign unused_addr_hi = ^bus.fmc_addr[15:4];

  fmc_stream_fifo_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .fmc_ne_i  (bus.fmc_ne),
    .fmc_noe_i (bus.fmc_noe),
    .ne_s_o    (ne_s),
    .noe_s_o   (noe_s),
    .noe_fall_o(noe_fall),
    .noe_rise_o(noe_rise)
  );

  // Next-state: pop/refill/bypass/push decisions, stickies and flush
  always_comb begin
    pop_evt   = noe_rise & sel_q;
    pop_ok    = pop_evt & head_valid_q;
    full      = (count_q == CNT_FULL);
    // Start a memory read when the head is (or is becoming) empty; a pop at
    // full frees a memory slot in the same cycle so a push still fits.
    issue     = (count_q != '0) & ~fetch_q & (~head_valid_q | pop_ok);
    bypass    = ~head_valid_q & ~fetch_q & (count_q == '0) & noe_s;
    push_mem  = bus.s_valid & ~bypass & (~full | issue);
    load_head = fetch_q & noe_s;

    head_d       = head_q;
    head_valid_d = head_valid_q;
    fetch_d      = fetch_q;
    sel_d        = sel_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;

    if (bus.s_valid & bypass) begin
      head_d       = bus.s_data;
      head_valid_d = 1'b1;
    end
    if (pop_ok) head_valid_d = 1'b0;
    if (load_head) begin
      head_d       = rdata_q;
      head_valid_d = 1'b1;
      fetch_d      = 1'b0;
    end
    if (issue) fetch_d = 1'b1;

    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(issue);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push_mem);
    count_d  = count_q + CW'(push_mem) - CW'(issue);

    if (pop_evt & ~head_valid_q) unf_d = 1'b1;
    if (bus.s_valid & ~bypass & ~push_mem) ovf_d = 1'b1;
    if (noe_fall) sel_d = ~ne_s & (bus.fmc_addr[3:0] == FIFO_ADDR);

    if (bus.clr) begin
      head_valid_d = 1'b0;
      fetch_d      = 1'b0;
      sel_d        = 1'b0;
      ovf_d        = 1'b0;
      unf_d        = 1'b0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
    end

    level_d  = 16'(count_d) + 16'(fetch_d) + 16'(head_valid_d);
    status_d = pack_status(level_d, level_d == 16'd0, count_d == CNT_FULL,
                           ovf_d, unf_d);
  end

  // Control and status registers
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      fetch_q      <= 1'b0;
      sel_q        <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      status_q     <= STATUS_RESET;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      fetch_q      <= fetch_d;
      sel_q        <= sel_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      status_q     <= status_d;
    end
  end

  // Sample memory with registered read (read-before-write on the same slot)
  always_ff @(posedge clk_i) begin
    if (push_mem & ~bus.clr) mem_q[wr_ptr_q] <= bus.s_data;
    if (issue) rdata_q <= mem_q[rd_ptr_q];
  end

  assign bus.rd_data = head_valid_q ? head_q : 32'h0;
  assign bus.status  = status_q;
  assign bus.s_ready = ~status_q[STAT_FULL];

endmodule

// File: tb/tb_fmc_stream_fifo.sv
// Randomised self-checking bench for fmc_stream_fifo against a queue model.
module tb_fmc_stream_fifo;
  import fmc_stream_fifo_pkg::*;

  localparam int CAP = 513;

  logic clk;
  logic reset_n;
  fmc_stream_fifo_if bus_if ();

  fmc_stream_fifo dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_q[$];
  bit          m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = 32'h0;
    s[15:0]  = 16'(model_q.size());
    s[16]    = (model_q.size() == 0);
    s[17]    = (model_q.size() == CAP);
    s[18]    = m_ovf;
    s[19]    = m_unf;
    return s;
  endfunction

  function automatic logic [31:0] exp_head();
    return (model_q.size() > 0) ? model_q[0] : 32'h0;
  endfunction

  task automatic model_clear();
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic push_burst(input int n, input logic [31:0] base, input bit rnd);
    logic [31:0] w;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom() : base + 32'(i);
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = w;
      if (model_q.size() < CAP) model_q.push_back(w);
      else m_ovf = 1'b1;
      @(posedge clk); #1;
    end
    bus_if.s_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic start_read(input logic [3:0] addr, input logic ne_lvl);
    @(posedge clk); #1;
    bus_if.fmc_addr = {12'h000, addr};
    bus_if.fmc_ne   = ne_lvl;
    bus_if.fmc_noe  = 1'b0;
  endtask

  task automatic end_read();
    @(posedge clk); #1;
    bus_if.fmc_noe = 1'b1;
    bus_if.fmc_ne  = 1'b1;
  endtask

  task automatic host_read(input logic [3:0] addr, input logic ne_lvl, input string tag);
    logic [31:0] exp_rd;
    exp_rd = exp_head();
    start_read(addr, ne_lvl);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, "_rd"}, bus_if.rd_data, exp_rd);
    end
    end_read();
    if (!ne_lvl && addr == FMC_ADDR_FIFO) begin
      if (model_q.size() > 0) void'(model_q.pop_front());
      else m_unf = 1'b1;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    check({tag, "_st"}, bus_if.status, exp_status());
    check({tag, "_head"}, bus_if.rd_data, exp_head());
  endtask

  task automatic pulse_clr(input bit with_push);
    @(posedge clk); #1;
    bus_if.clr     = 1'b1;
    bus_if.s_valid = with_push;
    bus_if.s_data  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_if.clr     = 1'b0;
    bus_if.s_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] y;
    int op;
    reset_n         = 1'b0;
    bus_if.s_data   = 32'h0;
    bus_if.s_valid  = 1'b0;
    bus_if.clr      = 1'b0;
    bus_if.fmc_addr = 16'h0;
    bus_if.fmc_ne   = 1'b1;
    bus_if.fmc_noe  = 1'b1;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_rd", bus_if.rd_data, 32'h0);
    check("rst_status", bus_if.status, 32'h0001_0000);
    check("rst_ready", {31'h0, bus_if.s_ready}, 32'h1);

    // single word bypass: valid one cycle after s_valid sampled
    @(posedge clk); #1;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 32'hA5A5_0001;
    model_q.push_back(32'hA5A5_0001);
    @(posedge clk); #1;
    bus_if.s_valid = 1'b0;
    @(negedge clk);
    check("byp_rd", bus_if.rd_data, 32'hA5A5_0001);
    check("byp_level", {16'h0, bus_if.status[15:0]}, 32'd1);
    host_read(FMC_ADDR_FIFO, 1'b0, "single");
    check("single_empty", bus_if.status, 32'h0001_0000);

    // underflow and address filter
    host_read(FMC_ADDR_FIFO, 1'b0, "unf");
    push_burst(3, 32'h1111_0000, 1'b0);
    host_read(4'h2, 1'b0, "addr2");
    host_read(FMC_ADDR_FIFO, 1'b1, "ne_hi");
    pulse_clr(1'b1);
    @(negedge clk);
    check("clr_push", bus_if.status, 32'h0001_0000);

    // ordering / full / overflow
    push_burst(512, 32'd1, 1'b0);
    @(negedge clk);
    check("lvl512", bus_if.status, exp_status());
    push_burst(88, 32'd513, 1'b0);
    @(negedge clk);
    check("lvl513", bus_if.status, exp_status());
    check("full_ready", {31'h0, bus_if.s_ready}, 32'h0);
    for (int i = 0; i < CAP; i++) host_read(FMC_ADDR_FIFO, 1'b0, "order");
    check("order_empty", bus_if.status, 32'h0005_0000);

    // push landing in the pop cycle at full
    pulse_clr(1'b0);
    push_burst(CAP, 32'h2000_0000, 1'b0);
    start_read(FMC_ADDR_FIFO, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pf_rd", bus_if.rd_data, exp_head());
    end_read();
    y = 32'hC0DE_0513;
    repeat (2) @(posedge clk);
    #1;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = y;
    @(posedge clk); #1;
    bus_if.s_valid = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(y);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("pf_status", bus_if.status, exp_status());
    check("pf_head", bus_if.rd_data, exp_head());

    // head must not load while NOE is low
    pulse_clr(1'b0);
    start_read(FMC_ADDR_STATUS, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 32'h7777_0042;
    model_q.push_back(32'h7777_0042);
    @(posedge clk); #1;
    bus_if.s_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("noe_hold_rd", bus_if.rd_data, 32'h0);
    check("noe_hold_st", bus_if.status, exp_status());
    end_read();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("noe_rel_rd", bus_if.rd_data, 32'h7777_0042);

    // reset mid-read at level 10
    pulse_clr(1'b0);
    push_burst(10, 32'h3000_0000, 1'b0);
    start_read(FMC_ADDR_FIFO, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_clear();
    repeat (4) @(posedge clk);
    end_read();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("rstmid_st", bus_if.status, 32'h0001_0000);
    check("rstmid_rd", bus_if.rd_data, 32'h0);

    // clr mid-read at level 10
    push_burst(10, 32'h4000_0000, 1'b0);
    host_read(FMC_ADDR_FIFO, 1'b0, "pre");
    start_read(FMC_ADDR_FIFO, 1'b0);
    repeat (4) @(posedge clk);
    pulse_clr(1'b0);
    end_read();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("clrmid_st", bus_if.status, 32'h0001_0000);
    check("clrmid_rd", bus_if.rd_data, 32'h0);

    // randomised traffic
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4) push_burst($urandom_range(1, 12), 32'h0, 1'b1);
      else if (op < 7) host_read(FMC_ADDR_FIFO, 1'b0, "rnd_pop");
      else if (op == 7) host_read(4'($urandom_range(0, 3)), 1'b0, "rnd_addr");
      else if (op == 8) host_read(FMC_ADDR_FIFO, 1'b1, "rnd_ne");
      else if ($urandom_range(0, 3) == 0) pulse_clr(1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    check("rnd_final", bus_if.status, exp_status());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
